// File: rtl/bundle_ctrl_pkg.sv
// Shared types and default constants for the bundling-kernel arbiter.
package bundle_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESULT} arb_state_t;

  localparam int unsigned DEFAULT_HV_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CLKS  = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [ID_W-1:0] gnt_id
);

  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bundle_kernel_arbiter.sv
// Frame-granular round-robin sharing of one bundling kernel between NUM_REQ requesters,
// with result routing and a watchdog on the wait for the kernel result.
module bundle_kernel_arbiter
  import bundle_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned HV_DATA_WIDTH = DEFAULT_HV_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CLKS  = DEFAULT_TIMEOUT_CLKS,
  localparam int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_first,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*HV_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               res_valid,
  output logic                             res_err,
  output logic [HV_DATA_WIDTH-1:0]         res_data,
  output logic                             k_valid,
  output logic                             k_first,
  output logic                             k_last,
  output logic [HV_DATA_WIDTH-1:0]         k_data_in,
  input  logic                             k_ready,
  input  logic                             k_done,
  input  logic [HV_DATA_WIDTH-1:0]         k_data_out,
  output logic                             busy,
  output logic [ID_W-1:0]                  grant_id,
  output logic                             proto_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS + 1);

  arb_state_t               state_q, state_d;
  logic [ID_W-1:0]          grant_q, grant_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                     started_q, started_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [HV_DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                     res_err_q, res_err_d;
  logic                     proto_err_q, proto_err_d;

  logic                     arb_valid;
  logic [ID_W-1:0]          arb_id;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req      (req_valid & req_first),
    .ptr      (rr_ptr_q),
    .gnt_valid(arb_valid),
    .gnt_id   (arb_id)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    started_d   = started_q;
    timer_d     = timer_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    proto_err_d = proto_err_q;
    k_valid     = 1'b0;
    k_first     = 1'b0;
    k_last      = 1'b0;
    k_data_in   = '0;
    req_ready   = '0;
    res_valid   = '0;

    unique case (state_q)
      IDLE: begin
        if (|(req_valid & ~req_first) || k_done) begin
          proto_err_d = 1'b1;
        end
        if (arb_valid) begin
          grant_d   = arb_id;
          started_d = 1'b0;
          state_d   = STREAM;
        end
      end

      STREAM: begin
        k_valid            = req_valid[grant_q];
        k_first            = req_first[grant_q];
        k_last             = req_last[grant_q];
        k_data_in          = req_data[32'(grant_q)*HV_DATA_WIDTH +: HV_DATA_WIDTH];
        req_ready[grant_q] = k_ready;
        if (k_valid && k_ready) begin
          started_d = 1'b1;
          // A restart mid-frame is flagged but still forwarded to the kernel.
          if (k_first && started_q) begin
            proto_err_d = 1'b1;
          end
          if (k_last) begin
            if (k_done) begin
              res_data_d = k_data_out;
              res_err_d  = 1'b0;
              state_d    = RESULT;
            end else begin
              timer_d = '0;
              state_d = WAIT_DONE;
            end
          end
        end
      end

      WAIT_DONE: begin
        // k_done takes priority over an expiring watchdog in the same cycle.
        if (k_done) begin
          res_data_d = k_data_out;
          res_err_d  = 1'b0;
          state_d    = RESULT;
        end else if (timer_q == TMR_W'(TIMEOUT_CLKS - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = RESULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RESULT: begin
        res_valid[grant_q] = 1'b1;
        if (k_done) begin
          proto_err_d = 1'b1;
        end
        rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      started_q   <= 1'b0;
      timer_q     <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      started_q   <= started_d;
      timer_q     <= timer_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bundle_kernel_arbiter.sv
// Directed self-checking bench for bundle_kernel_arbiter (4 requesters, 8-cycle watchdog).
module tb_bundle_kernel_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid, req_first, req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready, res_valid;
  logic         res_err;
  logic [31:0]  res_data;
  logic         k_valid, k_first, k_last;
  logic [31:0]  k_data_in;
  logic         k_ready, k_done;
  logic [31:0]  k_data_out;
  logic         busy;
  logic [1:0]   grant_id;
  logic         proto_err;

  int checks = 0;
  int errors = 0;

  bundle_kernel_arbiter #(
    .NUM_REQ      (4),
    .HV_DATA_WIDTH(32),
    .TIMEOUT_CLKS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_first (req_first),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_err   (res_err),
    .res_data  (res_data),
    .k_valid   (k_valid),
    .k_first   (k_first),
    .k_last    (k_last),
    .k_data_in (k_data_in),
    .k_ready   (k_ready),
    .k_done    (k_done),
    .k_data_out(k_data_out),
    .busy      (busy),
    .grant_id  (grant_id),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_first  = '0;
    req_last   = '0;
    req_data   = '0;
    k_ready    = 1'b0;
    k_done     = 1'b0;
    k_data_out = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_k_valid", 32'(k_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_proto", 32'(proto_err), 0);
    reset = 1'b0;

    // Single 3-beat frame from req0, result after one WAIT_DONE cycle
    req_valid = 4'b0001; req_first = 4'b0001; req_last = 4'b0000;
    req_data[31:0] = 32'h3F00_0000; k_ready = 1'b1;
    #1;
    chk("idle_ready", 32'(req_ready), 0);
    chk("idle_k_valid", 32'(k_valid), 0);
    tick();
    chk("sf_busy", 32'(busy), 1);
    chk("sf_grant", 32'(grant_id), 0);
    chk("sf_b0_first", 32'(k_first), 1);
    chk("sf_b0_data", k_data_in, 32'h3F00_0000);
    chk("sf_b0_ready", 32'(req_ready), 32'h1);
    tick();
    req_first = 4'b0000; #1;
    chk("sf_b1_first", 32'(k_first), 0);
    chk("sf_b1_valid", 32'(k_valid), 1);
    chk("sf_b1_data", k_data_in, 32'h3F00_0000);
    tick();
    req_last = 4'b0001; #1;
    chk("sf_b2_last", 32'(k_last), 1);
    tick();
    req_valid = 4'b0000; req_last = 4'b0000; #1;
    chk("wait_k_valid", 32'(k_valid), 0);
    chk("wait_ready", 32'(req_ready), 0);
    chk("wait_res_valid", 32'(res_valid), 0);
    chk("wait_busy", 32'(busy), 1);
    k_done = 1'b1; k_data_out = 32'h3F80_0000;
    tick();
    k_done = 1'b0; k_data_out = '0; #1;
    chk("sf_res_valid", 32'(res_valid), 32'h1);
    chk("sf_res_data", res_data, 32'h3F80_0000);
    chk("sf_res_err", 32'(res_err), 0);
    tick();
    chk("sf_res_drop", 32'(res_valid), 0);
    chk("sf_idle", 32'(busy), 0);
    chk("sf_res_hold", res_data, 32'h3F80_0000);
    chk("sf_proto", 32'(proto_err), 0);

    // Contention after reset: req0 and req2, single-beat frames with done on last
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ct_rst_data", res_data, 0);
    req_valid = 4'b0101; req_first = 4'b0101; req_last = 4'b0101;
    req_data[31:0] = 32'hAAAA_0000; req_data[95:64] = 32'h2222_2222;
    #1;
    chk("ct_idle_ready", 32'(req_ready), 0);
    tick();
    chk("ct_grant0", 32'(grant_id), 0);
    chk("ct_ready0", 32'(req_ready), 32'h1);
    chk("ct_data0", k_data_in, 32'hAAAA_0000);
    k_done = 1'b1; k_data_out = 32'h1111_1111;
    tick();
    k_done = 1'b0;
    req_valid = 4'b0100; req_first = 4'b0100; req_last = 4'b0100; #1;
    chk("ct_res0", 32'(res_valid), 32'h1);
    chk("ct_res0_data", res_data, 32'h1111_1111);
    chk("ct_res_ready", 32'(req_ready), 0);
    tick();
    chk("ct_idle_busy", 32'(busy), 0);
    chk("ct_idle_ready2", 32'(req_ready), 0);
    tick();
    chk("ct_grant2", 32'(grant_id), 2);
    chk("ct_ready2", 32'(req_ready), 32'h4);
    chk("ct_data2", k_data_in, 32'h2222_2222);
    chk("ct_last2", 32'(k_last), 1);
    k_done = 1'b1; k_data_out = 32'h3333_3333;
    tick();
    k_done = 1'b0; req_valid = '0; req_first = '0; req_last = '0; #1;
    chk("ct_res2", 32'(res_valid), 32'h4);
    chk("ct_res2_data", res_data, 32'h3333_3333);
    tick();
    chk("ct_proto", 32'(proto_err), 0);

    // Fairness: req1 and req3 always requesting; rr_ptr is 3 here
    req_valid = 4'b1010; req_first = 4'b1010; req_last = 4'b1010;
    req_data[63:32] = 32'h3F80_0000; req_data[127:96] = 32'h3F80_0000;
    k_data_out = 32'h3F80_0000;
    for (int f = 0; f < 8; f++) begin
      int exp_g;
      exp_g = (f % 2 == 0) ? 3 : 1;
      tick();
      chk("fair_grant", 32'(grant_id), 32'(exp_g));
      chk("fair_ready", 32'(req_ready), 32'(1) << exp_g);
      k_done = 1'b1;
      tick();
      k_done = 1'b0; #1;
      chk("fair_res", 32'(res_valid), 32'(1) << exp_g);
      tick();
    end
    req_valid = '0; req_first = '0; req_last = '0;
    chk("fair_proto", 32'(proto_err), 0);

    // Timeout: kernel never answers; rr_ptr is 2, req0 wraps around
    req_valid = 4'b0001; req_first = 4'b0001; req_last = 4'b0001;
    req_data[31:0] = 32'h3F80_0000; k_data_out = 32'hDEAD_BEEF;
    tick();
    chk("to_grant", 32'(grant_id), 0);
    tick();
    req_valid = '0; req_first = '0; req_last = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_wait_res", 32'(res_valid), 0);
      tick();
    end
    chk("to_res", 32'(res_valid), 32'h1);
    chk("to_err", 32'(res_err), 1);
    chk("to_data", res_data, 0);
    tick();
    chk("to_idle", 32'(busy), 0);
    chk("to_err_hold", 32'(res_err), 1);
    req_valid = 4'b0001; req_first = 4'b0001; req_last = 4'b0001;
    tick();
    chk("to_next_grant", 32'(grant_id), 0);
    k_done = 1'b1; k_data_out = 32'h3F80_0000;
    tick();
    k_done = 1'b0; req_valid = '0; req_first = '0; req_last = '0; #1;
    chk("to_next_res", 32'(res_valid), 32'h1);
    chk("to_next_err", 32'(res_err), 0);
    chk("to_next_data", res_data, 32'h3F80_0000);
    tick();

    // Reset mid-STREAM drops the frame, then a headless beat in IDLE flags proto_err
    req_valid = 4'b0100; req_first = 4'b0100; req_last = 4'b0000;
    req_data[95:64] = 32'h5555_5555; k_ready = 1'b0;
    tick();
    chk("mr_busy", 32'(busy), 1);
    chk("mr_grant", 32'(grant_id), 2);
    chk("mr_k_valid", 32'(k_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = '0; req_first = '0; #1;
    chk("mr_busy0", 32'(busy), 0);
    chk("mr_grant0", 32'(grant_id), 0);
    chk("mr_k_valid0", 32'(k_valid), 0);
    chk("mr_res_valid0", 32'(res_valid), 0);
    chk("mr_res_data0", res_data, 0);
    chk("mr_res_err0", 32'(res_err), 0);
    chk("mr_proto0", 32'(proto_err), 0);
    k_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_res", 32'(res_valid), 0);
    end
    req_valid = 4'b0010; req_first = 4'b0000;
    tick();
    chk("pe_flag", 32'(proto_err), 1);
    chk("pe_no_grant", 32'(busy), 0);
    tick();
    chk("pe_still_idle", 32'(busy), 0);
    chk("pe_sticky", 32'(proto_err), 1);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
